// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: merges load-use, divider and flush requests
// into one per-stage hold vector and sequences the iterative divider.
module pipe_stall_ctrl #(
  parameter int unsigned STALL_W     = 6,
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex_div,
  input  logic               div_ready,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               div_start,
  output logic               div_abort,
  output logic               div_busy,
  output logic               div_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int unsigned WD_W = 8;

  localparam logic [STALL_W-1:0] STALL_NONE    = '0;
  localparam logic [STALL_W-1:0] STALL_LOADUSE = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_DIV     = STALL_W'(6'b001111);
  localparam logic [WD_W-1:0]    WD_LAST       = WD_W'(DIV_TIMEOUT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            timeout_set;

  // Next-state and same-cycle control outputs; everything forced low in reset.
  always_comb begin
    state_nxt   = state;
    wd_cnt_nxt  = wd_cnt;
    timeout_set = 1'b0;
    stall       = STALL_NONE;
    flush       = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;

    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            flush = 1'b1;
          end else if (stallreq_ex_div) begin
            div_start  = 1'b1;
            stall      = STALL_DIV;
            state_nxt  = DIV_RUN;
            wd_cnt_nxt = '0;
          end else if (stallreq_id) begin
            stall = STALL_LOADUSE;
          end
        end

        DIV_RUN: begin
          // Load-use requests are subsumed by the DIV hold code here.
          if (flush_req) begin
            flush     = 1'b1;
            div_abort = 1'b1;
            state_nxt = IDLE;
          end else if (div_ready) begin
            state_nxt = IDLE;
          end else if (wd_cnt == WD_LAST) begin
            div_abort   = 1'b1;
            timeout_set = 1'b1;
            state_nxt   = IDLE;
          end else begin
            stall      = STALL_DIV;
            wd_cnt_nxt = wd_cnt + WD_W'(1);
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, watchdog, sticky timeout flag and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      div_busy     <= 1'b0;
      div_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      wd_cnt       <= wd_cnt_nxt;
      div_busy     <= (state_nxt == DIV_RUN);
      div_timeout  <= div_timeout | timeout_set;
      stall_cycles <= stall_cycles + CNT_W'(stall[0]);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl with hand-computed expectations.
module tb_pipe_stall_ctrl;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b000111;
  localparam logic [5:0] S_DIV  = 6'b001111;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex_div;
  logic        div_ready;
  logic        flush_req;
  logic [5:0]  stall;
  logic        flush;
  logic        div_start;
  logic        div_abort;
  logic        div_busy;
  logic        div_timeout;
  logic [31:0] stall_cycles;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_sc = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id     (stallreq_id),
    .stallreq_ex_div (stallreq_ex_div),
    .div_ready       (div_ready),
    .flush_req       (flush_req),
    .stall           (stall),
    .flush           (flush),
    .div_start       (div_start),
    .div_abort       (div_abort),
    .div_busy        (div_busy),
    .div_timeout     (div_timeout),
    .stall_cycles    (stall_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge, sample #2 later, well before the rising edge.
  task automatic apply(input logic r, input logic id, input logic dv, input logic rdy, input logic fl);
    @(negedge clk);
    rst = r; stallreq_id = id; stallreq_ex_div = dv; div_ready = rdy; flush_req = fl;
    #2;
  endtask

  task automatic chk_ctrl(input string tag, input logic [5:0] s, input logic f,
                          input logic st, input logic ab, input logic bz);
    check({tag, ".stall"},     64'(stall),     64'(s));
    check({tag, ".flush"},     64'(flush),     64'(f));
    check({tag, ".div_start"}, 64'(div_start), 64'(st));
    check({tag, ".div_abort"}, 64'(div_abort), 64'(ab));
    check({tag, ".div_busy"},  64'(div_busy),  64'(bz));
  endtask

  // Cycles 1..n of a DIV_RUN with no terminating event.
  task automatic div_hold(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_ctrl(tag, S_DIV, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b1; stallreq_ex_div = 1'b1; div_ready = 1'b1; flush_req = 1'b1;

    // Reset with every request asserted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_ctrl("reset", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.stall_cycles", 64'(stall_cycles), 64'd0);
      check("reset.div_timeout", 64'(div_timeout), 64'd0);
    end

    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("idle", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle load-use.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("loaduse", S_LU, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_sc += 1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("loaduse_end", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("loaduse.stall_cycles", 64'(stall_cycles), 64'(exp_sc));

    // div_ready outside a divide is ignored.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ctrl("idle_ready", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Divide: start at cycle 0, result at cycle 34.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("div_c0", S_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    div_hold("div_run", 33);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_ctrl("div_c34", S_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_sc += 34;

    // Back-to-back: new divide launches the very next cycle.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("b2b_start", S_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    check("div.stall_cycles", 64'(stall_cycles), 64'(exp_sc));
    div_hold("b2b_run", 9);

    // Flush at DIV_RUN cycle 10 with a load-use request also present.
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_ctrl("flush_div", S_NONE, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_sc += 10;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("flush_after", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush.div_timeout", 64'(div_timeout), 64'd0);
    check("flush.stall_cycles", 64'(stall_cycles), 64'(exp_sc));

    // div_ready coinciding with watchdog expiry: ready wins.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("race_start", S_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    div_hold("race_run", 39);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ctrl("race_c40", S_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_sc += 40;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("race.div_timeout", 64'(div_timeout), 64'd0);
    check("race.div_busy", 64'(div_busy), 64'd0);

    // Watchdog: no div_ready, abort on the 40th DIV_RUN cycle.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("wd_start", S_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    div_hold("wd_run", 39);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("wd_c40", S_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
    check("wd_c40.div_timeout", 64'(div_timeout), 64'd0);
    exp_sc += 40;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("wd_after", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wd.div_timeout", 64'(div_timeout), 64'd1);
    check("wd.stall_cycles", 64'(stall_cycles), 64'(exp_sc));

    // Flush in IDLE beats divide and load-use requests.
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_ctrl("flush_idle", S_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sticky.div_timeout", 64'(div_timeout), 64'd1);

    // Flush and div_ready together in DIV_RUN: flush wins, result dropped.
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("fr_start", S_DIV, 1'b0, 1'b1, 1'b0, 1'b0);
    div_hold("fr_run", 4);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ctrl("fr_c5", S_NONE, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_sc += 5;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("fr_after", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fr.stall_cycles", 64'(stall_cycles), 64'(exp_sc));
    check("fr.div_timeout", 64'(div_timeout), 64'd1);

    // Reset clears the sticky flag and the counter.
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctrl("rst2", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst2.div_timeout", 64'(div_timeout), 64'd0);
    check("rst2.stall_cycles", 64'(stall_cycles), 64'd0);
    check("rst2.div_busy", 64'(div_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage core (IF, ID, EX, MEM, WB); replaces the reset-only stall generator.
- Merges ID load-use requests, multi-cycle divider requests from EX and flush requests into one stall vector.
- Sequences the iterative divider through a start/busy/ready handshake.
- Keeps a watchdog and a stall-cycle performance counter.

Parameters:
- STALL_W, 6: stall vector width. Bit 0 holds PC, bit 1 IF/ID, bit 2 ID/EX, bit 3 EX/MEM, bit 4 MEM/WB, bit 5 WB.
- DIV_TIMEOUT, 40: maximum DIV_RUN cycles before abort; legal range 2..255.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- stallreq_id  in  1  load-use hazard detected in ID this cycle.
- stallreq_ex_div  in  1  EX holds a div/divu awaiting its result.
- div_ready  in  1  divider result valid this cycle; single-cycle pulse.
- flush_req  in  1  redirect/exception flush request.
- stall  out  STALL_W  per-stage hold vector.
- flush  out  1  clear IF/ID, ID/EX and EX/MEM this cycle.
- div_start  out  1  one-cycle divider launch pulse.
- div_abort  out  1  one-cycle divider kill pulse.
- div_busy  out  1  high while the state is DIV_RUN.
- div_timeout  out  1  sticky watchdog error flag.
- stall_cycles  out  CNT_W  cycles with stall[0]=1.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: state IDLE, wd_cnt 0, div_timeout 0, stall_cycles 0. While rst is high, all combinational outputs are 0.
- Stall semantics: stall[i]=1 holds stage i. stall[i]=1 with stall[i+1]=0 inserts a bubble into stage i+1.
- Fixed codes: LOADUSE = 6'b000111, DIV = 6'b001111, NONE = 6'b000000.
- Output timing: stall, flush, div_start and div_abort are combinational from state and inputs (same-cycle). State, counters and div_timeout are registered.
- Priority, highest first: rst, flush_req, divider, load-use.
- IDLE state:
  - flush_req=1: flush=1, stall=NONE, stay in IDLE.
  - Otherwise stallreq_ex_div=1: div_start=1, stall=DIV, next state DIV_RUN, wd_cnt<=0.
  - Otherwise stallreq_id=1: stall=LOADUSE, stay in IDLE. The load-use stall lasts one cycle unless ID re-asserts.
  - Otherwise stall=NONE.
- DIV_RUN state:
  - div_busy=1. stallreq_id is ignored because it is covered by the DIV code.
  - flush_req=1: flush=1, div_abort=1, stall=NONE, next state IDLE. The in-flight divide is discarded.
  - Otherwise div_ready=1: stall=NONE so EX latches the result and advances this edge; next state IDLE. stallreq_ex_div seen in IDLE on the following cycle belongs to a new instruction and starts a new divide (back-to-back divides allowed).
  - Otherwise wd_cnt==DIV_TIMEOUT-1: div_abort=1, stall=NONE, div_timeout<=1 (sticky until rst), next state IDLE.
  - Otherwise stall=DIV, wd_cnt<=wd_cnt+1.
- Same-cycle conflicts:
  - flush_req with div_ready in DIV_RUN: flush wins, div_abort=1, result dropped.
  - div_ready in IDLE: ignored.
  - div_ready with watchdog expiry in the same cycle: div_ready wins, no timeout flagged.
- stall_cycles: increments each cycle stall[0]=1 and rst=0. Wraps modulo 2^CNT_W with no saturation.
- div_start and div_abort are never high together.
- flush and stall!=NONE are never high together.

Test Plan:
- Reset: rst=1 for 3 cycles with all requests high -> stall=0, flush=0, div_start=0, stall_cycles=0. After release, state is IDLE.
- Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall=6'b000111 that cycle only, stall_cycles=1, div_busy=0.
- Divide: stallreq_ex_div=1 at cycle 0, div_ready pulsed at cycle 34 ->
  - div_start=1 at cycle 0 only.
  - stall=6'b001111 on cycles 0..33, 0 at cycle 34.
  - div_busy high on cycles 1..34.
  - stall_cycles=34.
- Flush during divide: flush_req=1 at cycle 10 of DIV_RUN with stallreq_id=1 -> flush=1, div_abort=1, stall=0 that cycle; IDLE next cycle; div_timeout stays 0.
- Watchdog: DIV_TIMEOUT=40, div_ready never asserted -> div_abort=1 and stall=0 on the 40th DIV_RUN cycle; div_timeout=1 from the next cycle and sticky until rst.
- Back-to-back divides: div_ready at cycle N with stallreq_ex_div high again at N+1 -> second div_start at N+1, stall=DIV resumes.
- Simultaneous flush_req and div_ready in DIV_RUN -> flush=1, div_abort=1.
